// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character buffer placed directly after the UART
// receiver. Each rising edge of rx_done pushes rx_data into a DEPTH-entry FIFO.
// The read port is first-word-fall-through. A sticky flag records characters
// lost because the FIFO was full and nobody popped in the same cycle.
module uart_rx_fifo #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_done,
  input  logic [SIZE-1:0]            rx_data,
  input  logic                       rd_en,
  output logic [SIZE-1:0]            rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [SIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            rx_done_q;

  logic            empty_s;
  logic            full_s;
  logic            wr_s;
  logic            rd_s;
  logic            push_s;
  logic            drop_s;

  // The flags are pure decodes of the registered occupancy.
  assign empty_s = (count_q == CNT_ZERO);
  assign full_s  = (count_q == CNT_DEPTH);

  // Strobe decode: one write per rx_done rising edge. Popping an empty FIFO
  // does nothing. A full FIFO still accepts a write when a pop frees a slot
  // in the same cycle.
  always_comb begin
    wr_s   = rx_done & ~rx_done_q;
    rd_s   = rd_en & ~empty_s;
    push_s = 1'b0;
    drop_s = 1'b0;
    if (wr_s) begin
      if (full_s && !rd_s) begin
        drop_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Next-state computation for the pointers, the occupancy and the sticky
  // overflow flag. A drop in the same cycle as clr_ovf leaves the flag set.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, rd_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state registers. rx_done_q resets low, so an rx_done that is
  // already high when reset is released counts as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rx_done_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rx_done_q <= rx_done;
    end
  end

  // Character storage. The contents are not reset because the pointers and
  // the occupancy decide what is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  // First-word-fall-through head. It is forced to zero while the FIFO is
  // empty so that stale memory never shows on the port.
  always_comb begin
    rd_data = '0;
    if (!empty_s) begin
      rd_data = mem_q[rd_ptr_q];
    end else begin
      rd_data = '0;
    end
  end

  assign empty    = empty_s;
  assign full     = full_s;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a vector table for the basic traffic,
// then hand-written sequences for the corner cases. A queue-based reference
// FIFO supplies the expected data and flags.
module tb_uart_rx_fifo;

  localparam int SIZE  = 8;
  localparam int DEPTH = 8;

  logic            clk;
  logic            rst;
  logic            rx_done;
  logic [SIZE-1:0] rx_data;
  logic            rd_en;
  logic            clr_ovf;
  logic [SIZE-1:0] rd_data;
  logic            empty;
  logic            full;
  logic [3:0]      count;
  logic            overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [SIZE-1:0] sb[$];
  logic            mdl_prev;
  logic            mdl_ovf;

  typedef struct {
    logic            rxd;
    logic [SIZE-1:0] data;
    logic            rden;
    logic            clr;
    int              exp_count;
    logic [SIZE-1:0] exp_head;
  } vec_t;

  vec_t tv[$];

  uart_rx_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every output against the reference model state.
  task automatic chk_state(input string tag);
    logic [SIZE-1:0] head;
    head = (sb.size() == 0) ? 8'h00 : sb[0];
    chk({tag, "_count"}, 32'(count), 32'(sb.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(sb.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(sb.size() == DEPTH));
    chk({tag, "_ovf"},   32'(overflow), 32'(mdl_ovf));
    chk({tag, "_head"},  32'(rd_data), 32'(head));
  endtask

  // One clock cycle: drive the inputs, check the popped character against the
  // scoreboard, advance the model, then check the state after the edge.
  task automatic step(input logic rxd, input logic [SIZE-1:0] data,
                      input logic rden, input logic clr);
    logic wr;
    logic rd;
    logic [SIZE-1:0] exp_pop;
    rx_done = rxd;
    rx_data = data;
    rd_en   = rden;
    clr_ovf = clr;
    #1;
    wr = rxd & ~mdl_prev;
    rd = rden & (sb.size() != 0);
    if (rd) begin
      exp_pop = sb.pop_front();
      chk("pop_data", 32'(rd_data), 32'(exp_pop));
    end
    if (wr) begin
      if (sb.size() < DEPTH) begin
        sb.push_back(data);
      end else begin
        mdl_ovf = 1'b1;
      end
    end
    if (clr && !(wr && sb.size() == DEPTH && !rd)) begin
      if (!(wr && !rd && sb.size() == DEPTH)) mdl_ovf = mdl_ovf & ~(clr & ~(wr & ~rd & (sb.size() == DEPTH)));
    end
    mdl_prev = rxd;
    @(posedge clk);
    #1;
    chk_state("step");
  endtask

  // Issue one write as a single-cycle pulse followed by one idle cycle.
  task automatic write_char(input logic [SIZE-1:0] data, input logic rden);
    step(1'b1, data, rden, 1'b0);
    step(1'b0, data, 1'b0, 1'b0);
  endtask

  task automatic tv_add(input logic rxd, input logic [SIZE-1:0] data, input logic rden,
                        input int exp_count, input logic [SIZE-1:0] exp_head);
    vec_t v;
    v.rxd = rxd; v.data = data; v.rden = rden; v.clr = 1'b0;
    v.exp_count = exp_count; v.exp_head = exp_head;
    tv.push_back(v);
  endtask

  task automatic model_reset();
    sb.delete();
    mdl_prev = 1'b0;
    mdl_ovf  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rx_done = 1'b0; rx_data = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
    model_reset();

    // The vector table: an idle pop on the empty FIFO, three spaced pulses,
    // then three pops and one extra pop on the empty FIFO.
    for (int i = 0; i < 3; i++) tv_add(1'b0, 8'h00, 1'b1, 0, 8'h00);
    tv_add(1'b1, 8'h41, 1'b0, 1, 8'h41);
    for (int i = 0; i < 4; i++) tv_add(1'b0, 8'h00, 1'b0, 1, 8'h41);
    tv_add(1'b1, 8'h42, 1'b0, 2, 8'h41);
    for (int i = 0; i < 4; i++) tv_add(1'b0, 8'h00, 1'b0, 2, 8'h41);
    tv_add(1'b1, 8'h43, 1'b0, 3, 8'h41);
    tv_add(1'b0, 8'h00, 1'b0, 3, 8'h41);
    tv_add(1'b0, 8'h00, 1'b1, 2, 8'h42);
    tv_add(1'b0, 8'h00, 1'b1, 1, 8'h43);
    tv_add(1'b0, 8'h00, 1'b1, 0, 8'h00);
    tv_add(1'b0, 8'h00, 1'b1, 0, 8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_rdata", 32'(rd_data), 32'd0);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rxd, tv[i].data, tv[i].rden, tv[i].clr);
      chk($sformatf("tv%0d_count", i), 32'(count), 32'(tv[i].exp_count));
      chk($sformatf("tv%0d_head", i),  32'(rd_data), 32'(tv[i].exp_head));
      chk($sformatf("tv%0d_empty", i), 32'(empty), 32'(tv[i].exp_count == 0));
    end

    // A level held high for five cycles yields exactly one entry.
    repeat (5) step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("level_count", 32'(count), 32'd1);
    chk("level_head",  32'(rd_data), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill the FIFO, then drop one character while full.
    for (int i = 0; i < DEPTH; i++) write_char(8'(i), 1'b0);
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd8);
    write_char(8'hFF, 1'b0);
    chk("drop_ovf",   32'(overflow), 32'd1);
    chk("drop_count", 32'(count), 32'd8);
    chk("drop_head",  32'(rd_data), 32'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Clear overflow with no drop in the same cycle.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Full FIFO: a write together with a pop is accepted and wraps around.
    for (int i = 0; i < DEPTH; i++) write_char(8'(i), 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    chk("pp_count", 32'(count), 32'd8);
    chk("pp_ovf",   32'(overflow), 32'd0);
    chk("pp_head",  32'(rd_data), 32'h01);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // An empty FIFO given a write together with rd_en performs the write only.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("empty_wr_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // When a drop and clr_ovf land in the same cycle, the set wins.
    for (int i = 0; i < DEPTH; i++) write_char(8'(8'h10 + i), 1'b0);
    write_char(8'hEE, 1'b0);
    step(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("setwin_ovf", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-operation with four entries stored.
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd4);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ovf",   32'(overflow), 32'd0);
    chk("mid_rst_rdata", 32'(rd_data), 32'd0);
    model_reset();

    // rx_done already high as reset is released counts as an edge.
    rx_done = 1'b1;
    rx_data = 8'h3C;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_rst_edge_count", 32'(count), 32'd1);
    chk("post_rst_edge_head",  32'(rd_data), 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
